hdmi_rx_sm: RTL and testbench
=============================

HDMI_RX_SM -- requirements
Module: hdmi_rx_sm

Interface
REQ-001 Parameter MAX_PACKETS, default 18: maximum 32-pixel packets per data island.
REQ-002 Parameter PREAMBLE_LEN, default 8: consecutive identical preamble characters required.
REQ-003 clk_pixel  input  1  pixel clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 tmds  input  30  word-aligned TMDS characters, ch0=[9:0], ch1=[19:10], ch2=[29:20].
REQ-006 mode  output  3  decoded period: 0 control, 1 video, 2 video guard, 3 data island, 4 data-island guard.
REQ-007 rgb  output  24  decoded video pixel, ch0 in [7:0], ch1 in [15:8], ch2 in [23:16]; valid when de=1.
REQ-008 de  output  1  video data period active.
REQ-009 hsync, vsync  output  1 each  sync recovered from ch0 control or TERC4 bits [1:0].
REQ-010 di_data  output  12  TERC4 nibbles {ch2,ch1,ch0}; valid when di_valid=1.
REQ-011 di_valid  output  1  data island payload character valid.
REQ-012 packet_start  output  1  pulses with first character of each 32-pixel packet.
REQ-013 err  output  1  one-cycle pulse on any protocol violation (REQ-022).

Function
REQ-014 Stage 1 shall classify each channel character: control token (1101010100=00, 0010101011=01, 0101010100=10, 1010101011=11), video guard (ch0/ch2 1011001100, ch1 0100110011), TERC4 (HDMI 1.4 16-entry table), else video.
REQ-015 Video decode: if bit9 set invert bits[7:0]; out0=d0; outi = d[i]^d[i-1] when bit8=1, else XNOR.
REQ-016 Total latency tmds to every output shall be exactly 2 clk_pixel cycles.
REQ-017 FSM states: CTRL, PRE_V, PRE_D, GUARD_V, VIDEO, GUARD_DL, ISLAND, GUARD_DT.
REQ-018 CTRL: all-channel control tokens with {CTL3..CTL0}=0001 increment preamble count into PRE_V; 0101 into PRE_D; any other value clears count.
REQ-019 PRE_x -> GUARD_x only when count >= PREAMBLE_LEN and matching guard appears (video: REQ-014 pattern; island: ch1/ch2 0100110011, ch0 TERC4 {1,1,vsync,hsync}); count saturates at PREAMBLE_LEN.
REQ-020 GUARD_V requires exactly 2 guard characters then VIDEO; VIDEO stays while characters decode as video; any control token -> CTRL with de=0.
REQ-021 GUARD_DL requires exactly 2 characters then ISLAND; ISLAND counts pixels 0..31 (5-bit wrap) and packets; packet_start when pixel count = 0; guard character at pixel count 0 after >=1 packet -> GUARD_DT (2 characters) -> CTRL.
REQ-022 err pulses and FSM returns to CTRL on: guard count != 2, preamble < PREAMBLE_LEN before guard, non-TERC4 character in ISLAND, trailing guard not on 32-boundary, packet count exceeding MAX_PACKETS.
REQ-023 hsync/vsync shall update in CTRL (ch0 token bits) and ISLAND/GUARD_D (ch0 TERC4 bits[1:0]) and hold otherwise.
REQ-024 mode shall be 2 during GUARD_V, 4 during GUARD_DL/GUARD_DT, 3 in ISLAND, 1 in VIDEO, else 0.
REQ-025 rgb and di_data shall hold last valid value when their valid strobe is low.

Reset
REQ-026 reset shall force state CTRL, counters 0, mode=0, rgb=0, de=0, hsync=0, vsync=0, di_data=0, di_valid=0, packet_start=0, err=0 on next edge.
REQ-027 reset asserted mid-period shall abort it without err; pipeline contents discarded; outputs valid 2 cycles after reset release.

Verification
REQ-028 8 control chars CTL=0001 + 2 video guards + pixel 0xFF0080 -> mode 2 for 2 cycles, then de=1, rgb=0xFF0080, 2-cycle latency.
REQ-029 Island: 8 preamble (0101) + 2 guards + 64 TERC4 + 2 guards -> packet_start at pixel 0 and 32, di_valid 64 cycles, mode 4,3,4,0.
REQ-030 Only 7 preamble chars then video guard -> err=1, de stays 0, mode 0.
REQ-031 Trailing guard at island pixel 17 -> err=1, state CTRL.
REQ-032 19 consecutive packets with MAX_PACKETS=18 -> err at packet 19 start.
REQ-033 reset mid-VIDEO -> all outputs 0 next cycle, err=0, subsequent valid preamble decoded normally.

Source files
------------

// File: rtl/hdmi_rx_sm.sv
// HDMI receiver period tracker: classifies word-aligned TMDS characters and
// follows control/preamble/guard/video/data-island periods, decoding payloads.
module hdmi_rx_sm #(
  parameter int MAX_PACKETS  = 18,
  parameter int PREAMBLE_LEN = 8
) (
  input  logic        clk_pixel,
  input  logic        reset,
  input  logic [29:0] tmds,
  output logic [2:0]  mode,
  output logic [23:0] rgb,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] di_data,
  output logic        di_valid,
  output logic        packet_start,
  output logic        err
);
  localparam int PCW = $clog2(PREAMBLE_LEN + 1);
  localparam int KCW = $clog2(MAX_PACKETS + 1);

  localparam logic [9:0] GUARD_A = 10'b1011001100;
  localparam logic [9:0] GUARD_B = 10'b0100110011;

  localparam logic [2:0] M_CTRL = 3'd0;
  localparam logic [2:0] M_VID  = 3'd1;
  localparam logic [2:0] M_VG   = 3'd2;
  localparam logic [2:0] M_DI   = 3'd3;
  localparam logic [2:0] M_DG   = 3'd4;

  typedef enum logic [2:0] {
    CTRL, PRE_V, PRE_D, GUARD_V, VIDEO, GUARD_DL, ISLAND, GUARD_DT
  } state_t;

  // {valid, token[1:0]}
  function automatic logic [2:0] ctrl_decode(input logic [9:0] c);
    case (c)
      10'b1101010100: return 3'b100;
      10'b0010101011: return 3'b101;
      10'b0101010100: return 3'b110;
      10'b1010101011: return 3'b111;
      default:        return 3'b000;
    endcase
  endfunction

  // {valid, nibble[3:0]}
  function automatic logic [4:0] terc4_decode(input logic [9:0] c);
    case (c)
      10'b1010011100: return 5'h10;
      10'b1001100011: return 5'h11;
      10'b1011100100: return 5'h12;
      10'b1011100010: return 5'h13;
      10'b0101110001: return 5'h14;
      10'b0100011110: return 5'h15;
      10'b0110001110: return 5'h16;
      10'b0100111100: return 5'h17;
      10'b1011001100: return 5'h18;
      10'b0100111001: return 5'h19;
      10'b0110011100: return 5'h1A;
      10'b1011000110: return 5'h1B;
      10'b1010001110: return 5'h1C;
      10'b1001110001: return 5'h1D;
      10'b0101100011: return 5'h1E;
      10'b1011000011: return 5'h1F;
      default:        return 5'h00;
    endcase
  endfunction

  function automatic logic [7:0] video_decode(input logic [9:0] c);
    logic [7:0] d;
    logic [7:0] q;
    d    = c[9] ? ~c[7:0] : c[7:0];
    q[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = c[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    return q;
  endfunction

  function automatic logic [PCW-1:0] sat_inc(input logic [PCW-1:0] c);
    return (c >= PCW'(PREAMBLE_LEN)) ? c : c + PCW'(1);
  endfunction

  logic [2:0] c0, c1, c2;
  logic [4:0] t0, t1, t2;
  assign c0 = ctrl_decode(tmds[9:0]);
  assign c1 = ctrl_decode(tmds[19:10]);
  assign c2 = ctrl_decode(tmds[29:20]);
  assign t0 = terc4_decode(tmds[9:0]);
  assign t1 = terc4_decode(tmds[19:10]);
  assign t2 = terc4_decode(tmds[29:20]);

  // Stage p0: per-channel classification and video decode
  logic        vld_p0;
  logic [2:0]  ctl_ok_p0;
  logic [5:0]  tok_p0;
  logic [2:0]  terc_ok_p0;
  logic [11:0] nib_p0;
  logic        vguard_p0;
  logic        dguard_p0;
  logic [23:0] pix_p0;

  always_ff @(posedge clk_pixel) begin
    if (reset) vld_p0 <= 1'b0;
    else       vld_p0 <= 1'b1;
  end

  always_ff @(posedge clk_pixel) begin
    ctl_ok_p0  <= {c2[2], c1[2], c0[2]};
    tok_p0     <= {c2[1:0], c1[1:0], c0[1:0]};
    terc_ok_p0 <= {t2[4], t1[4], t0[4]};
    nib_p0     <= {t2[3:0], t1[3:0], t0[3:0]};
    vguard_p0  <= (tmds[29:20] == GUARD_A) && (tmds[19:10] == GUARD_B) &&
                  (tmds[9:0] == GUARD_A);
    dguard_p0  <= (tmds[29:20] == GUARD_B) && (tmds[19:10] == GUARD_B) &&
                  t0[4] && (t0[3:2] == 2'b11);
    pix_p0     <= {video_decode(tmds[29:20]), video_decode(tmds[19:10]),
                   video_decode(tmds[9:0])};
  end

  state_t          state;
  logic [PCW-1:0]  pre_cnt;
  logic [1:0]      grd_cnt;
  logic [4:0]      pix_cnt;
  logic [KCW-1:0]  pkt_cnt;

  // Where a control-period character leads: preamble tracking on {CTL3..CTL0}
  state_t         ctl_state;
  logic [PCW-1:0] ctl_cnt;
  logic [3:0]     ctl_code;
  logic           all_ctl;
  logic           pre_ok;
  assign all_ctl  = &ctl_ok_p0;
  assign ctl_code = tok_p0[5:2];
  assign pre_ok   = (pre_cnt >= PCW'(PREAMBLE_LEN));

  always_comb begin
    ctl_state = CTRL;
    ctl_cnt   = '0;
    if (all_ctl && ctl_code == 4'b0001) begin
      ctl_state = PRE_V;
      ctl_cnt   = (state == PRE_V) ? sat_inc(pre_cnt) : PCW'(1);
    end else if (all_ctl && ctl_code == 4'b0101) begin
      ctl_state = PRE_D;
      ctl_cnt   = (state == PRE_D) ? sat_inc(pre_cnt) : PCW'(1);
    end
  end

  // Stage p1: period state machine with registered outputs
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state        <= CTRL;
      pre_cnt      <= '0;
      grd_cnt      <= '0;
      pix_cnt      <= '0;
      pkt_cnt      <= '0;
      mode         <= M_CTRL;
      rgb          <= '0;
      de           <= 1'b0;
      hsync        <= 1'b0;
      vsync        <= 1'b0;
      di_data      <= '0;
      di_valid     <= 1'b0;
      packet_start <= 1'b0;
      err          <= 1'b0;
    end else if (vld_p0) begin
      de           <= 1'b0;
      di_valid     <= 1'b0;
      packet_start <= 1'b0;
      err          <= 1'b0;
      case (state)
        CTRL, PRE_V, PRE_D: begin
          if (state == PRE_V && vguard_p0) begin
            pre_cnt <= '0;
            if (pre_ok) begin
              state   <= GUARD_V;
              mode    <= M_VG;
              grd_cnt <= 2'd1;
            end else begin
              state <= CTRL;
              mode  <= M_CTRL;
              err   <= 1'b1;
            end
          end else if (state == PRE_D && dguard_p0) begin
            pre_cnt        <= '0;
            {vsync, hsync} <= nib_p0[1:0];
            if (pre_ok) begin
              state   <= GUARD_DL;
              mode    <= M_DG;
              grd_cnt <= 2'd1;
            end else begin
              state <= CTRL;
              mode  <= M_CTRL;
              err   <= 1'b1;
            end
          end else begin
            state   <= ctl_state;
            mode    <= M_CTRL;
            pre_cnt <= ctl_cnt;
            if (ctl_ok_p0[0]) {vsync, hsync} <= tok_p0[1:0];
          end
        end
        GUARD_V: begin
          if (grd_cnt == 2'd1 && vguard_p0) begin
            grd_cnt <= 2'd2;
          end else if (grd_cnt == 2'd1 || vguard_p0) begin
            state <= CTRL;
            mode  <= M_CTRL;
            err   <= 1'b1;
          end else if (|ctl_ok_p0) begin
            state   <= ctl_state;
            mode    <= M_CTRL;
            pre_cnt <= ctl_cnt;
            if (ctl_ok_p0[0]) {vsync, hsync} <= tok_p0[1:0];
          end else begin
            state <= VIDEO;
            mode  <= M_VID;
            de    <= 1'b1;
            rgb   <= pix_p0;
          end
        end
        VIDEO: begin
          if (|ctl_ok_p0) begin
            state   <= ctl_state;
            mode    <= M_CTRL;
            pre_cnt <= ctl_cnt;
            if (ctl_ok_p0[0]) {vsync, hsync} <= tok_p0[1:0];
          end else begin
            de  <= 1'b1;
            rgb <= pix_p0;
          end
        end
        GUARD_DL: begin
          if (grd_cnt == 2'd1 && dguard_p0) begin
            grd_cnt        <= 2'd2;
            {vsync, hsync} <= nib_p0[1:0];
          end else if (grd_cnt == 2'd2 && &terc_ok_p0) begin
            state          <= ISLAND;
            mode           <= M_DI;
            di_valid       <= 1'b1;
            di_data        <= nib_p0;
            packet_start   <= 1'b1;
            pix_cnt        <= 5'd1;
            pkt_cnt        <= KCW'(1);
            {vsync, hsync} <= nib_p0[1:0];
          end else begin
            state <= CTRL;
            mode  <= M_CTRL;
            err   <= 1'b1;
          end
        end
        ISLAND: begin
          if (dguard_p0 && pix_cnt == 5'd0 && pkt_cnt != '0) begin
            state          <= GUARD_DT;
            mode           <= M_DG;
            grd_cnt        <= 2'd1;
            {vsync, hsync} <= nib_p0[1:0];
          end else if (&terc_ok_p0 &&
                       !(pix_cnt == 5'd0 && pkt_cnt == KCW'(MAX_PACKETS))) begin
            di_valid       <= 1'b1;
            di_data        <= nib_p0;
            pix_cnt        <= pix_cnt + 5'd1;
            {vsync, hsync} <= nib_p0[1:0];
            if (pix_cnt == 5'd0) begin
              packet_start <= 1'b1;
              pkt_cnt      <= pkt_cnt + KCW'(1);
            end
          end else begin
            state <= CTRL;
            mode  <= M_CTRL;
            err   <= 1'b1;
          end
        end
        GUARD_DT: begin
          if (grd_cnt == 2'd1 && dguard_p0) begin
            grd_cnt        <= 2'd2;
            {vsync, hsync} <= nib_p0[1:0];
          end else if (grd_cnt == 2'd1 || dguard_p0) begin
            state <= CTRL;
            mode  <= M_CTRL;
            err   <= 1'b1;
          end else begin
            state   <= ctl_state;
            mode    <= M_CTRL;
            pre_cnt <= ctl_cnt;
            if (ctl_ok_p0[0]) {vsync, hsync} <= tok_p0[1:0];
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hdmi_rx_sm.sv
// Directed bench for hdmi_rx_sm: reset, video period, data island, preamble,
// guard-alignment and packet-limit errors, and reset during video.
module tb_hdmi_rx_sm;
  logic        clk_pixel = 1'b0;
  logic        reset;
  logic [29:0] tmds;
  logic [2:0]  mode;
  logic [23:0] rgb;
  logic        de;
  logic        hsync;
  logic        vsync;
  logic [11:0] di_data;
  logic        di_valid;
  logic        packet_start;
  logic        err;

  int tests  = 0;
  int failed = 0;

  localparam logic [9:0]  T00 = 10'b1101010100;
  localparam logic [9:0]  T01 = 10'b0010101011;
  localparam logic [9:0]  GA  = 10'b1011001100;
  localparam logic [9:0]  GB  = 10'b0100110011;
  localparam logic [29:0] IDLE  = {T00, T00, T01};
  localparam logic [29:0] PRE_V = {T00, T01, T01};
  localparam logic [29:0] PRE_D = {T01, T01, T01};
  localparam logic [29:0] VG    = {GA, GB, GA};
  localparam logic [29:0] DG    = {GB, GB, 10'b1001110001};
  localparam logic [29:0] PIX_A = {10'b0101010101, 10'b0100000000, 10'b0110000000};
  localparam logic [23:0] RGB_A = 24'hFF0080;
  localparam logic [29:0] PIX_B = {10'b1100001111, 10'b0000000000, 10'b1000000000};
  localparam logic [23:0] RGB_B = 24'h10FEFF;

  hdmi_rx_sm dut (
    .clk_pixel   (clk_pixel),
    .reset       (reset),
    .tmds        (tmds),
    .mode        (mode),
    .rgb         (rgb),
    .de          (de),
    .hsync       (hsync),
    .vsync       (vsync),
    .di_data     (di_data),
    .di_valid    (di_valid),
    .packet_start(packet_start),
    .err         (err)
  );

  always #5 clk_pixel = ~clk_pixel;

  function automatic logic [9:0] terc(input logic [3:0] n);
    case (n)
      4'h0: return 10'b1010011100;
      4'h1: return 10'b1001100011;
      4'h2: return 10'b1011100100;
      4'h3: return 10'b1011100010;
      4'h4: return 10'b0101110001;
      4'h5: return 10'b0100011110;
      4'h6: return 10'b0110001110;
      4'h7: return 10'b0100111100;
      4'h8: return 10'b1011001100;
      4'h9: return 10'b0100111001;
      4'hA: return 10'b0110011100;
      4'hB: return 10'b1011000110;
      4'hC: return 10'b1010001110;
      4'hD: return 10'b1001110001;
      4'hE: return 10'b0101100011;
      default: return 10'b1011000011;
    endcase
  endfunction

  function automatic logic [11:0] isl_di(input int k);
    return {k[3:0], ~k[3:0], k[5:4], 2'b01};
  endfunction

  function automatic logic [29:0] isl_char(input int k);
    logic [11:0] d;
    d = isl_di(k);
    return {terc(d[11:8]), terc(d[7:4]), terc(d[3:0])};
  endfunction

  // Apply a character, clock it in, and settle; outputs then show the previous character.
  task automatic send(input logic [29:0] c);
    tmds = c;
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    send(PIX_A);
    send(VG);
    tests++; if (mode !== 3'd0) begin failed++; $display("FAIL reset_mode: got %0d want 0", mode); end
    tests++; if (rgb !== 24'd0) begin failed++; $display("FAIL reset_rgb: got %h want 0", rgb); end
    tests++; if ({de, hsync, vsync} !== 3'b000) begin failed++; $display("FAIL reset_de_sync: got %b want 000", {de, hsync, vsync}); end
    tests++; if (di_data !== 12'd0) begin failed++; $display("FAIL reset_di_data: got %h want 0", di_data); end
    tests++; if ({di_valid, packet_start, err} !== 3'b000) begin failed++; $display("FAIL reset_strobes: got %b want 000", {di_valid, packet_start, err}); end
    reset = 1'b0;
    send(IDLE);
    tests++; if ({mode, de, err} !== 5'd0) begin failed++; $display("FAIL reset_release: got mode=%0d de=%b err=%b want 0", mode, de, err); end
  endtask

  task automatic test_video();
    logic [29:0] c;
    int m;
    logic [2:0] em;
    logic ede;
    for (int n = 0; n < 16; n++) begin
      if (n < 2) c = IDLE; else if (n < 10) c = PRE_V; else if (n < 12) c = VG;
      else if (n == 12) c = PIX_A; else if (n == 13) c = PIX_B; else c = IDLE;
      send(c);
      m   = n - 1;
      em  = (m == 10 || m == 11) ? 3'd2 : (m == 12 || m == 13) ? 3'd1 : 3'd0;
      ede = (m == 12 || m == 13);
      tests++;
      if (mode !== em || de !== ede || err !== 1'b0) begin
        failed++;
        $display("FAIL video_ctl m=%0d: got mode=%0d de=%b err=%b want mode=%0d de=%b err=0", m, mode, de, err, em, ede);
      end
      if (m == 12) begin
        tests++; if (rgb !== RGB_A) begin failed++; $display("FAIL video_rgb_a: got %h want %h", rgb, RGB_A); end
      end
      if (m == 13 || m == 14) begin
        tests++; if (rgb !== RGB_B) begin failed++; $display("FAIL video_rgb_b m=%0d: got %h want %h", m, rgb, RGB_B); end
      end
    end
    tests++; if ({vsync, hsync} !== 2'b01) begin failed++; $display("FAIL video_sync: got %b want 01", {vsync, hsync}); end
  endtask

  task automatic test_island();
    logic [29:0] c;
    int m;
    logic [2:0] em;
    logic edv, eps;
    for (int n = 0; n < 81; n++) begin
      if (n < 2) c = IDLE; else if (n < 10) c = PRE_D; else if (n < 12) c = DG;
      else if (n < 76) c = isl_char(n - 12); else if (n < 78) c = DG; else c = IDLE;
      send(c);
      m   = n - 1;
      em  = (m < 10) ? 3'd0 : (m < 12) ? 3'd4 : (m < 76) ? 3'd3 : (m < 78) ? 3'd4 : 3'd0;
      edv = (m >= 12 && m < 76);
      eps = (m == 12 || m == 44);
      tests++;
      if (mode !== em || di_valid !== edv || packet_start !== eps || err !== 1'b0) begin
        failed++;
        $display("FAIL island_ctl m=%0d: got mode=%0d dv=%b ps=%b err=%b want mode=%0d dv=%b ps=%b err=0",
                 m, mode, di_valid, packet_start, err, em, edv, eps);
      end
      if (edv) begin
        tests++;
        if (di_data !== isl_di(m - 12)) begin
          failed++;
          $display("FAIL island_data m=%0d: got %h want %h", m, di_data, isl_di(m - 12));
        end
      end
    end
    tests++; if (di_data !== isl_di(63)) begin failed++; $display("FAIL island_hold: got %h want %h", di_data, isl_di(63)); end
    tests++; if ({vsync, hsync} !== 2'b01) begin failed++; $display("FAIL island_sync: got %b want 01", {vsync, hsync}); end
  endtask

  task automatic test_short_preamble();
    logic [29:0] c;
    int m;
    for (int n = 0; n < 14; n++) begin
      if (n < 2) c = IDLE; else if (n < 9) c = PRE_V; else if (n < 11) c = VG;
      else if (n == 11) c = PIX_A; else c = IDLE;
      send(c);
      m = n - 1;
      tests++;
      if (err !== (m == 9) || de !== 1'b0 || mode !== 3'd0) begin
        failed++;
        $display("FAIL short_pre m=%0d: got err=%b de=%b mode=%0d want err=%b de=0 mode=0", m, err, de, mode, (m == 9));
      end
    end
  endtask

  task automatic test_bad_trailing_guard();
    logic [29:0] c;
    int m;
    logic [2:0] em;
    for (int n = 0; n < 32; n++) begin
      if (n < 2) c = IDLE; else if (n < 10) c = PRE_D; else if (n < 12) c = DG;
      else if (n < 29) c = isl_char(n - 12); else if (n == 29) c = DG; else c = IDLE;
      send(c);
      m  = n - 1;
      em = (m == 10 || m == 11) ? 3'd4 : (m >= 12 && m < 29) ? 3'd3 : 3'd0;
      tests++;
      if (err !== (m == 29) || mode !== em || packet_start !== (m == 12)) begin
        failed++;
        $display("FAIL trail_guard m=%0d: got err=%b mode=%0d ps=%b want err=%b mode=%0d ps=%b",
                 m, err, mode, packet_start, (m == 29), em, (m == 12));
      end
    end
  endtask

  task automatic test_max_packets();
    logic [29:0] c;
    int m;
    int ps_cnt = 0;
    int err_cnt = 0;
    for (int n = 0; n < 623; n++) begin
      if (n < 2) c = IDLE; else if (n < 10) c = PRE_D; else if (n < 12) c = DG;
      else if (n < 620) c = isl_char(n - 12); else c = IDLE;
      send(c);
      m = n - 1;
      if (packet_start === 1'b1) ps_cnt++;
      if (err === 1'b1) err_cnt++;
      if (m == 587) begin
        tests++; if (mode !== 3'd3 || err !== 1'b0) begin failed++; $display("FAIL maxpkt_before: got mode=%0d err=%b want 3 0", mode, err); end
      end
      if (m == 588) begin
        tests++; if (err !== 1'b1 || packet_start !== 1'b0 || mode !== 3'd0) begin
          failed++; $display("FAIL maxpkt_err: got err=%b ps=%b mode=%0d want 1 0 0", err, packet_start, mode);
        end
      end
      if (m == 589) begin
        tests++; if (di_valid !== 1'b0 || mode !== 3'd0) begin failed++; $display("FAIL maxpkt_after: got dv=%b mode=%0d want 0 0", di_valid, mode); end
      end
    end
    tests++; if (ps_cnt != 18) begin failed++; $display("FAIL maxpkt_starts: got %0d want 18", ps_cnt); end
    tests++; if (err_cnt != 1) begin failed++; $display("FAIL maxpkt_errs: got %0d want 1", err_cnt); end
  endtask

  task automatic test_reset_mid_video();
    logic [29:0] c;
    int m;
    for (int n = 0; n < 15; n++) begin
      if (n < 2) c = IDLE; else if (n < 10) c = PRE_V; else if (n < 12) c = VG; else c = PIX_A;
      send(c);
    end
    tests++; if (de !== 1'b1 || rgb !== RGB_A) begin failed++; $display("FAIL rstvid_pre: got de=%b rgb=%h want 1 %h", de, rgb, RGB_A); end
    reset = 1'b1;
    send(PIX_A);
    tests++; if ({mode, de, hsync, vsync, di_valid, packet_start, err} !== 9'd0) begin
      failed++; $display("FAIL rstvid_ctl: got mode=%0d de=%b hs=%b vs=%b dv=%b ps=%b err=%b want 0",
                         mode, de, hsync, vsync, di_valid, packet_start, err);
    end
    tests++; if (rgb !== 24'd0 || di_data !== 12'd0) begin failed++; $display("FAIL rstvid_data: got rgb=%h di=%h want 0", rgb, di_data); end
    reset = 1'b0;
    send(PIX_A);
    tests++; if (de !== 1'b0 || rgb !== 24'd0 || err !== 1'b0) begin failed++; $display("FAIL rstvid_discard: got de=%b rgb=%h err=%b want 0", de, rgb, err); end
    for (int n = 0; n < 15; n++) begin
      if (n < 2) c = IDLE; else if (n < 10) c = PRE_V; else if (n < 12) c = VG;
      else if (n == 12) c = PIX_B; else c = IDLE;
      send(c);
      m = n - 1;
      tests++; if (err !== 1'b0) begin failed++; $display("FAIL rstvid_err m=%0d: got %b want 0", m, err); end
      if (m == 11) begin
        tests++; if (mode !== 3'd2 || de !== 1'b0) begin failed++; $display("FAIL rstvid_guard: got mode=%0d de=%b want 2 0", mode, de); end
      end
      if (m == 12) begin
        tests++; if (mode !== 3'd1 || de !== 1'b1 || rgb !== RGB_B) begin
          failed++; $display("FAIL rstvid_pixel: got mode=%0d de=%b rgb=%h want 1 1 %h", mode, de, rgb, RGB_B);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    tmds  = '0;
    test_reset();
    test_video();
    test_island();
    test_short_preamble();
    test_bad_trailing_guard();
    test_max_packets();
    test_reset_mid_video();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
